// File: rtl/ddr_cmd_issuer_pkg.sv
// Shared types for the DDR command issuer: scheduler command codes, FIFO entry layout,
// DDR pin patterns and the per-bank readiness bundle.
package ddr_cmd_issuer_pkg;

    typedef enum logic [3:0] {
        CmdNop = 4'd0,
        CmdAct = 4'd1,
        CmdRd  = 4'd2,
        CmdWr  = 4'd3,
        CmdPre = 4'd4,
        CmdRef = 4'd5
    } sch_cmd_t;

    typedef struct packed {
        sch_cmd_t    cmd;
        logic [13:0] addr;
        logic [2:0]  bank;
    } sch_entry_t;

    localparam int unsigned ISU_FIFO_WIDTH = 21;

    // {ras_n, cas_n, we_n} with cs_n low
    localparam logic [2:0] PinAct = 3'b011;
    localparam logic [2:0] PinRd  = 3'b101;
    localparam logic [2:0] PinWr  = 3'b100;
    localparam logic [2:0] PinPre = 3'b010;
    localparam logic [2:0] PinRef = 3'b001;
    localparam logic [2:0] PinNop = 3'b111;

    typedef struct packed {
        logic rcd_ok;
        logic ras_ok;
        logic rp_ok;
    } bank_rdy_t;

endpackage

// File: rtl/ddr_bank_timer.sv
// One bank's open flag plus its tRCD/tRAS/tRP down-counters; each counter loads T-1 on its
// triggering command and saturates at zero.
module ddr_bank_timer
    import ddr_cmd_issuer_pkg::*;
#(
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_RP  = 3,
    parameter int unsigned T_RAS = 8,
    parameter int unsigned T_CCD = 2,
    parameter int unsigned CNT_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      act_i,
    input  logic      pre_i,
    input  logic      auto_pre_i,
    output logic      open_o,
    output bank_rdy_t rdy_o
);

    localparam logic [CNT_W-1:0] RcdLoad   = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RasLoad   = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RpLoad    = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RpApLoad  = CNT_W'(T_RP + T_CCD - 1);
    localparam logic [CNT_W-1:0] One       = CNT_W'(1);

    logic             open_q, open_d;
    logic [CNT_W-1:0] rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d;

    always_comb begin
        open_d = open_q;
        rcd_d  = (rcd_q != '0) ? rcd_q - One : '0;
        ras_d  = (ras_q != '0) ? ras_q - One : '0;
        rp_d   = (rp_q != '0) ? rp_q - One : '0;
        if (act_i) begin
            open_d = 1'b1;
            rcd_d  = RcdLoad;
            ras_d  = RasLoad;
        end
        if (pre_i) begin
            open_d = 1'b0;
            rp_d   = RpLoad;
        end
        if (auto_pre_i) begin
            open_d = 1'b0;
            rp_d   = RpApLoad;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            open_q <= 1'b0;
            rcd_q  <= '0;
            ras_q  <= '0;
            rp_q   <= '0;
        end else begin
            open_q <= open_d;
            rcd_q  <= rcd_d;
            ras_q  <= ras_d;
            rp_q   <= rp_d;
        end
    end

    assign open_o       = open_q;
    assign rdy_o.rcd_ok = (rcd_q == '0);
    assign rdy_o.ras_ok = (ras_q == '0);
    assign rdy_o.rp_ok  = (rp_q == '0);

endmodule

// File: rtl/ddr_cmd_issuer.sv
// Pops scheduled commands from the issue FIFO head and drives registered DDR command pins once
// every bank/global timing constraint is met. DDR_CMD_ISSUER_AUTO_PRE_EN enables addr[10] auto-precharge.
module ddr_cmd_issuer
    import ddr_cmd_issuer_pkg::*;
#(
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_RP  = 3,
    parameter int unsigned T_RAS = 8,
    parameter int unsigned T_RFC = 20,
    parameter int unsigned T_CCD = 2,
    parameter int unsigned CNT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fifo_empty_i,
    input  logic [ISU_FIFO_WIDTH-1:0] fifo_data_i,
    output logic                      fifo_ren_o,
    output logic                      ddr_cs_n_o,
    output logic                      ddr_ras_n_o,
    output logic                      ddr_cas_n_o,
    output logic                      ddr_we_n_o,
    output logic [2:0]                ddr_ba_o,
    output logic [13:0]               ddr_addr_o,
    output logic                      issue_valid_o,
    output logic [7:0]                bank_open_o,
    output logic                      err_o
);

    localparam logic [CNT_W-1:0] CcdLoad = CNT_W'(T_CCD - 1);
    localparam logic [CNT_W-1:0] RfcLoad = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] One     = CNT_W'(1);

    sch_entry_t      head;
    logic [2:0]      bnk;
    bank_rdy_t [7:0] rdy;
    logic [7:0]      bank_open, rp_ok_vec, act_vec, pre_vec, ap_vec;
    logic            rfc_ok, ap_req;
    logic            issue, pop, err_set, act_v, pre_v, ap_v, col_v, ref_v;
    logic [2:0]      pin_d;

    logic             cs_n_q, iv_q, err_q;
    logic [2:0]       pins_q, ba_q;
    logic [13:0]      addr_q;
    logic [CNT_W-1:0] ccd_q, ccd_d, rfc_q, rfc_d;

    assign head   = sch_entry_t'(fifo_data_i);
    assign bnk    = head.bank;
    assign rfc_ok = (rfc_q == '0);

`ifdef DDR_CMD_ISSUER_AUTO_PRE_EN
    assign ap_req = head.addr[10];
`else
    assign ap_req = 1'b0;
`endif

    always_comb begin
        issue   = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        act_v   = 1'b0;
        pre_v   = 1'b0;
        ap_v    = 1'b0;
        col_v   = 1'b0;
        ref_v   = 1'b0;
        pin_d   = PinNop;
        if (!fifo_empty_i) begin
            case (head.cmd)
                CmdNop: pop = rfc_ok;
                CmdAct: begin
                    if (bank_open[bnk]) begin
                        err_set = 1'b1;
                    end else if (rfc_ok && rdy[bnk].rp_ok) begin
                        issue = 1'b1;
                        act_v = 1'b1;
                        pin_d = PinAct;
                    end
                end
                CmdRd, CmdWr: begin
                    if (!bank_open[bnk]) begin
                        err_set = 1'b1;
                    end else if (rfc_ok && rdy[bnk].rcd_ok && ccd_q == '0) begin
                        issue = 1'b1;
                        col_v = 1'b1;
                        ap_v  = ap_req;
                        pin_d = (head.cmd == CmdRd) ? PinRd : PinWr;
                    end
                end
                CmdPre: begin
                    // A closed bank still gets PRE on the pins but keeps its state.
                    if (rfc_ok && rdy[bnk].ras_ok) begin
                        issue = 1'b1;
                        pre_v = bank_open[bnk];
                        pin_d = PinPre;
                    end
                end
                CmdRef: begin
                    if (bank_open != '0) begin
                        err_set = 1'b1;
                    end else if (rfc_ok && &rp_ok_vec) begin
                        issue = 1'b1;
                        ref_v = 1'b1;
                        pin_d = PinRef;
                    end
                end
                default: err_set = 1'b1;
            endcase
        end
        pop = pop | issue | err_set;
    end

    assign fifo_ren_o = pop & rst_n;

    assign act_vec = act_v ? (8'd1 << bnk) : 8'd0;
    assign pre_vec = pre_v ? (8'd1 << bnk) : 8'd0;
    assign ap_vec  = ap_v ? (8'd1 << bnk) : 8'd0;

    for (genvar i = 0; i < 8; i++) begin : g_bank
        ddr_bank_timer #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .T_CCD (T_CCD),
            .CNT_W (CNT_W)
        ) u_bank_timer (
            .clk        (clk),
            .rst_n      (rst_n),
            .act_i      (act_vec[i]),
            .pre_i      (pre_vec[i]),
            .auto_pre_i (ap_vec[i]),
            .open_o     (bank_open[i]),
            .rdy_o      (rdy[i])
        );
        assign rp_ok_vec[i] = rdy[i].rp_ok;
    end

    always_comb begin
        ccd_d = (ccd_q != '0) ? ccd_q - One : '0;
        rfc_d = (rfc_q != '0) ? rfc_q - One : '0;
        if (col_v) ccd_d = CcdLoad;
        if (ref_v) rfc_d = RfcLoad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_n_q <= 1'b1;
            pins_q <= PinNop;
            ba_q   <= '0;
            addr_q <= '0;
            iv_q   <= 1'b0;
            err_q  <= 1'b0;
            ccd_q  <= '0;
            rfc_q  <= '0;
        end else begin
            cs_n_q <= 1'b0;
            pins_q <= pin_d;
            iv_q   <= issue;
            err_q  <= err_q | err_set;
            ccd_q  <= ccd_d;
            rfc_q  <= rfc_d;
            if (issue) begin
                ba_q   <= bnk;
                addr_q <= head.addr;
            end
        end
    end

    assign ddr_cs_n_o    = cs_n_q;
    assign ddr_ras_n_o   = pins_q[2];
    assign ddr_cas_n_o   = pins_q[1];
    assign ddr_we_n_o    = pins_q[0];
    assign ddr_ba_o      = ba_q;
    assign ddr_addr_o    = addr_q;
    assign issue_valid_o = iv_q;
    assign bank_open_o   = bank_open;
    assign err_o         = err_q;

endmodule
